// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, data width and multiply/divide state encoding
package cpu_pkg;
    localparam int DATA_W = 32;

    localparam logic [4:0] OPC_MUL = 5'b01111;
    localparam logic [4:0] OPC_DIV = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FINISH
    } md_state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shared accumulator/shift registers for one Booth or restoring-divide step per enable
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   booth_sum, shifted, diff;

    // mode=0: Booth multiply (m = multiplicand, q = multiplier)
    // mode=1: restoring divide (m = divisor magnitude, q = dividend magnitude shifting into quotient)
    always_comb begin
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        booth_sum = acc_q;
        shifted   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff      = shifted - m_q;
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase

        if (load) begin
            acc_d = '0;
            qm1_d = 1'b0;
            q_d   = mode ? opa : opb;
            m_d   = mode ? {1'b0, opb} : {opa[WIDTH-1], opa};
        end else if (step) begin
            if (mode) begin
                if (!diff[WIDTH]) begin
                    acc_d = diff;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_d, q_d, qm1_d} = {booth_sum[WIDTH], booth_sum, q_q};
            end
        end
    end

    // Both modes leave the high half in acc and the low half in q.
    assign hi_next = acc_d[WIDTH-1:0];
    assign lo_next = q_d;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc_q <= '0;
            m_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed multiply/divide engine driving the Z result pair
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo
);
    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_neg_q, a_neg_d;
    logic             q_neg_q, q_neg_d;
    logic             bz_q, bz_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;

    logic [4:0]       opcode;
    logic             accept_mul, accept_div, last;
    logic             dp_load, dp_step, dp_mode;
    logic [WIDTH-1:0] a_mag, b_mag, dp_opa, dp_opb, hi_next, lo_next;
    logic             unused_op;

    assign opcode     = op[31:27];
    assign unused_op  = ^op[26:0];
    assign accept_mul = start && (opcode == OPC_MUL);
    assign accept_div = start && (opcode == OPC_DIV);
    assign last       = (cnt_q == CNT_W'(WIDTH - 1));
    assign a_mag      = A[WIDTH-1] ? -A : A;
    assign b_mag      = B[WIDTH-1] ? -B : B;
    assign dp_opa     = accept_div ? a_mag : A;
    assign dp_opb     = accept_div ? b_mag : B;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_neg_d = a_neg_q;
        q_neg_d = q_neg_q;
        bz_d    = bz_q;
        dbz_d   = dbz_q;
        a_d     = a_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        dp_mode = (state_q == DIV);
        case (state_q)
            IDLE: begin
                if (accept_mul || accept_div) begin
                    state_d = accept_mul ? MUL : DIV;
                    dp_load = 1'b1;
                    dp_mode = accept_div;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    a_d     = A;
                    a_neg_d = A[WIDTH-1];
                    q_neg_d = A[WIDTH-1] ^ B[WIDTH-1];
                    bz_d    = (B == '0);
                end
            end
            MUL, DIV: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = FINISH;
                    if (state_q == MUL) begin
                        zhi_d = hi_next;
                        zlo_d = lo_next;
                    end else if (bz_q) begin
                        // The iteration still ran on a zero divisor so latency stays fixed.
                        zhi_d = a_q;
                        zlo_d = '1;
                        dbz_d = 1'b1;
                    end else begin
                        zhi_d = a_neg_q ? -hi_next : hi_next;
                        zlo_d = q_neg_q ? -lo_next : lo_next;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock   (clock),
        .clear   (clear),
        .load    (dp_load),
        .step    (dp_step),
        .mode    (dp_mode),
        .opa     (dp_opa),
        .opb     (dp_opb),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
            bz_q    <= 1'b0;
            dbz_q   <= 1'b0;
            a_q     <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_neg_q <= a_neg_d;
            q_neg_q <= q_neg_d;
            bz_q    <= bz_d;
            dbz_q   <= dbz_d;
            a_q     <= a_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
        end
    end

    assign busy        = (state_q == MUL) || (state_q == DIV);
    assign done        = (state_q == FINISH);
    assign div_by_zero = dbz_q;
    assign zhi         = zhi_q;
    assign zlo         = zlo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_ADD = 5'b00011;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op    = '0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] zhi, zlo;

    int checks   = 0;
    int failures = 0;
    int lat, bcnt, stable;
    logic dz0;

    always #5 clock = ~clock;

    muldiv_unit dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .zhi         (zhi),
        .zlo         (zlo)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // inj_kind 1: re-pulse start with a DIV opcode at iteration inj_iter
    // inj_kind 2: async clear at iteration inj_iter, checked immediately
    task automatic run_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int inj_iter, input int inj_kind,
                          output int lat_o, output int busy_o, output int stable_o, output logic dz_o);
        logic [31:0] prev_hi, prev_lo;
        int aborted;
        lat_o = 0; busy_o = 0; stable_o = 1; dz_o = 1'bx; aborted = 0;
        @(negedge clock);
        prev_hi = zhi; prev_lo = zlo;
        op = {opc, 27'h15a5a5}; A = a; B = b; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; op = '0; A = 32'hdeadbeef; B = 32'h12345678;
        for (int k = 1; k <= 40 && lat_o == 0; k++) begin
            if (k == 1) dz_o = div_by_zero;
            if (busy) busy_o++;
            if (aborted == 0 && (zhi !== prev_hi || zlo !== prev_lo)) stable_o = 0;
            if (k == inj_iter && inj_kind == 1) begin
                start = 1'b1; op = {OP_DIV, 27'h0};
            end
            if (k == inj_iter && inj_kind == 2) begin
                #1 clear = 1'b1;
                #1;
                check_eq("abort_busy", {31'b0, busy}, 32'h0);
                check_eq("abort_zhi", zhi, 32'h0);
                check_eq("abort_zlo", zlo, 32'h0);
                clear = 1'b0;
                aborted = 1;
            end
            @(posedge clock);
            @(negedge clock);
            if (k == inj_iter && inj_kind == 1) begin
                start = 1'b0; op = '0;
            end
            if (done) lat_o = k;
        end
    endtask

    initial begin
        #2 clear = 1'b1;
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        check_eq("rst_done", {31'b0, done}, 32'h0);
        check_eq("rst_dbz", {31'b0, div_by_zero}, 32'h0);
        check_eq("rst_zhi", zhi, 32'h0);
        check_eq("rst_zlo", zlo, 32'h0);
        repeat (2) @(negedge clock);
        clear = 1'b0;

        run_op(OP_ADD, 32'd1, 32'd2, 0, 0, lat, bcnt, stable, dz0);
        check_eq("add_no_done", lat, 0);
        check_eq("add_no_busy", bcnt, 0);

        run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 0, 0, lat, bcnt, stable, dz0);
        check_eq("mul1_latency", lat, 32);
        check_eq("mul1_busy_cycles", bcnt, 32);
        check_eq("mul1_stable", stable, 1);
        check_eq("mul1_zhi", zhi, 32'hFFFFFFFF);
        check_eq("mul1_zlo", zlo, 32'hFFFFFFEB);
        check_eq("mul1_busy_at_done", {31'b0, busy}, 32'h0);
        @(negedge clock);
        check_eq("mul1_done_pulse", {31'b0, done}, 32'h0);

        run_op(OP_MUL, 32'h80000000, 32'h80000000, 0, 0, lat, bcnt, stable, dz0);
        check_eq("mul2_latency", lat, 32);
        check_eq("mul2_zhi", zhi, 32'h40000000);
        check_eq("mul2_zlo", zlo, 32'h00000000);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, lat, bcnt, stable, dz0);
        check_eq("div1_latency", lat, 32);
        check_eq("div1_zlo", zlo, 32'hFFFFFFFD);
        check_eq("div1_zhi", zhi, 32'hFFFFFFFF);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, bcnt, stable, dz0);
        check_eq("div2_zlo", zlo, 32'h80000000);
        check_eq("div2_zhi", zhi, 32'h0);
        check_eq("div2_dbz", {31'b0, div_by_zero}, 32'h0);

        run_op(OP_DIV, 32'd5, 32'd0, 0, 0, lat, bcnt, stable, dz0);
        check_eq("dbz_latency", lat, 32);
        check_eq("dbz_flag", {31'b0, div_by_zero}, 32'h1);
        check_eq("dbz_zlo", zlo, 32'hFFFFFFFF);
        check_eq("dbz_zhi", zhi, 32'd5);

        run_op(OP_MUL, 32'd3, 32'd4, 5, 1, lat, bcnt, stable, dz0);
        check_eq("dbz_clear_at_accept", {31'b0, dz0}, 32'h0);
        check_eq("mul3_latency", lat, 32);
        check_eq("mul3_zhi", zhi, 32'h0);
        check_eq("mul3_zlo", zlo, 32'd12);
        @(negedge clock);
        check_eq("mul3_no_restart", {31'b0, busy}, 32'h0);

        run_op(OP_MUL, 32'd3, 32'd4, 10, 2, lat, bcnt, stable, dz0);
        check_eq("abort_no_done", lat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine beside the combinational ALU.
- Handles the MUL and DIV opcodes, which the ALU leaves to this block.
- Latches operands on a start pulse and iterates one bit per clock.
- Drives a 64-bit result (HI/LO halves) into the Z result register pair.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  in  1  system clock, rising-edge
clear  in  1  reset, asynchronous, active-high
start  in  1  request pulse; sampled only in IDLE
op  in  32  instruction word; opcode is op[31:27]
A  in  WIDTH  multiplicand / dividend
B  in  WIDTH  multiplier / divisor
busy  out  1  high from the accepting edge until the done edge
done  out  1  one-cycle pulse; results valid
div_by_zero  out  1  sticky flag for the last DIV; cleared on next accepted start
zhi  out  WIDTH  product[63:32] or remainder
zlo  out  WIDTH  product[31:0] or quotient

Behaviour:
- Reset (clear=1, async): state=IDLE; busy, done, div_by_zero, zhi, zlo all 0; counter 0.
- Clear mid-operation aborts immediately: no done pulse, and no partial result is kept.
- States:
  - IDLE -> MUL on start && op[31:27]==OPC_MUL.
  - IDLE -> DIV on start && op[31:27]==OPC_DIV.
  - MUL/DIV -> FINISH after WIDTH iterations.
  - FINISH -> IDLE unconditionally.
- start with any other opcode is ignored: stays IDLE, no done.
- start while busy is ignored; there is no queueing.
- Accepting edge E0:
  - A, B and the operation are latched into internal registers; later input changes have no effect.
  - busy=1; div_by_zero=0; counter=0.
- Iteration edges E1..E32: one iteration per edge.
- At E32: zhi/zlo written, done=1, busy=0, state FINISH.
- At E33: done=0, state IDLE.
- Latency is a fixed 32 cycles from the accepting edge to done for both ops, including divide-by-zero.
- A new start is accepted no earlier than the edge after done; back-to-back throughput is one op per 34 cycles.
- zhi/zlo hold their value until the next completion or clear. They do not change during iteration.
- MUL:
  - Radix-2 Booth, signed two's complement, full 64-bit product {zhi,zlo}.
  - Accumulator is WIDTH+1 bits to absorb the Booth add/sub overflow.
  - 0x80000000*0x80000000 must produce 0x40000000_00000000.
- DIV:
  - Signed; quotient truncates toward zero; remainder takes the dividend's sign.
  - zlo=quotient, zhi=remainder.
  - Implemented as an unsigned restoring divide on magnitudes, with sign correction applied at E32.
  - Overflow case 0x80000000 / 0xFFFFFFFF: zlo=0x80000000, zhi=0, div_by_zero=0.
- DIV with B==0:
  - div_by_zero=1 at E32.
  - zlo=0xFFFFFFFF, zhi=A as latched.
  - Full 32-cycle latency is preserved.
- Operation encodings: op[26:0] is don't-care.

Decomposition:
- Shared package cpu_pkg:
  - OPC_MUL=5'b01111, OPC_DIV=5'b10000 (the same 5-bit opcode constants the ALU decodes).
  - State enum {IDLE, MUL, DIV, FINISH}.
  - DATA_W=32.
- One natural sub-module: muldiv_datapath. It holds the accumulator/shift registers and performs one Booth or restore step per enable, selected by a mode bit.
- muldiv_unit keeps the FSM, counter, operand latching, sign fix-up and output registers.

Test Plan:
- Reset with clear pulsed async between edges -> all outputs 0 immediately. start=1 with op[31:27]=00011 (ADD) -> busy stays 0 and done never rises within 40 cycles.
- MUL A=7, B=0xFFFFFFFD (-3) -> done exactly 32 cycles after the accepting edge. zhi=0xFFFFFFFF, zlo=0xFFFFFFEB; busy high for cycles 0..31.
- MUL A=B=0x80000000 -> zhi=0x40000000, zlo=0x00000000.
- DIV A=0xFFFFFFF9 (-7), B=2 -> zlo=0xFFFFFFFD, zhi=0xFFFFFFFF. Then DIV A=0x80000000, B=0xFFFFFFFF -> zlo=0x80000000, zhi=0, div_by_zero=0.
- DIV A=5, B=0 -> after 32 cycles div_by_zero=1, zlo=0xFFFFFFFF, zhi=5. Then a following MUL start -> div_by_zero clears at the accepting edge.
- During a MUL (A=3, B=4), pulse start with a DIV opcode at iteration 5 -> ignored; result still zhi=0, zlo=12. In a second run, assert clear at iteration 10 -> busy=0 and zhi/zlo=0 at once, with no done pulse afterwards.
